// File: rtl/bus_share_arbiter_if.sv
// Signal bundle between the shared-bus arbiter and its requesters/consumer.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface bus_share_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic [7:0]         Req;
    logic [8*WIDTH-1:0] DataIn;
    logic               BusReady;
    logic [7:0]         Grant;
    logic               S0;
    logic               S1;
    logic               S2;
    logic [WIDTH-1:0]   BusData;
    logic               BusValid;
    logic [7:0]         BeatDone;

    modport slave (
        input  Req, DataIn, BusReady,
        output Grant, S0, S1, S2, BusData, BusValid, BeatDone
    );

    modport master (
        output Req, DataIn, BusReady,
        input  Grant, S0, S1, S2, BusData, BusValid, BeatDone
    );
endinterface

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter for an 8-source shared bus with bounded bursts.
// Each grant is followed by one IDLE bubble before the next arbitration.
module bus_share_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    bus_share_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        grant_q, grant_d;
    logic [2:0]        sel_q,   sel_d;
    logic [2:0]        ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [2:0]        pick_idx;
    logic              pick_vld;
    logic              valid;
    logic              hshk;
    logic              last_beat;

    assign valid     = (state_q == BUSY) && bus.Req[sel_q];
    assign hshk      = valid && bus.BusReady;
    assign last_beat = (cnt_q == CNT_W'(MAX_BEATS - 1));

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        pick_idx = ptr_q;
        pick_vld = 1'b0;
        for (int unsigned i = 8; i > 0; i--) begin
            logic [2:0] cand;
            cand = ptr_q + 3'(i - 1);
            if (bus.Req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    grant_d = 8'b1 << pick_idx;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // A dropped request releases without counting, even if BusReady is high.
                if (!bus.Req[sel_q] || (hshk && last_beat)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + 3'd1;
                end
                if (hshk) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.Grant    = grant_q;
        bus.S0       = sel_q[0];
        bus.S1       = sel_q[1];
        bus.S2       = sel_q[2];
        bus.BusData  = bus.DataIn[sel_q*WIDTH +: WIDTH];
        bus.BusValid = valid;
        bus.BeatDone = hshk ? (8'b1 << sel_q) : '0;
    end

    grant_onehot_a: assert property (@(posedge Clk) disable iff (!ResetN) $onehot0(grant_q));

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: accepted beats are matched against a queue of
// expected (lane, data) pairs; grant/select timing is checked directly.
module tb_bus_share_arbiter;

    localparam int unsigned W = 16;

    logic Clk = 1'b0;
    logic ResetN;

    always #5 Clk = ~Clk;

    bus_share_arbiter_if #(.WIDTH(W)) bus ();

    bus_share_arbiter #(.WIDTH(W), .MAX_BEATS(4)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]   lane;
        logic [W-1:0] data;
    } beat_t;

    beat_t sb[$];
    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    bit mon_en = 1'b0;

    function automatic logic [W-1:0] lane_val(input int unsigned i);
        if (i == 5) return 16'hA5A5;
        return 16'hC000 | 16'(i * 16'h0111);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic expect_beats(input int unsigned lane, input int unsigned n);
        beat_t b;
        b.lane = 3'(lane);
        b.data = lane_val(lane);
        for (int unsigned k = 0; k < n; k++) sb.push_back(b);
    endtask

    task automatic do_reset();
        ResetN  = 1'b0;
        bus.Req = '0;
        tick(1);
        ResetN  = 1'b1;
        tick(1);
    endtask

    function automatic logic [2:0] sel();
        return {bus.S2, bus.S1, bus.S0};
    endfunction

    // Every accepted beat must match the head of the expectation queue.
    always @(negedge Clk) begin
        if (mon_en && bus.BeatDone !== 8'h00) begin
            if (sb.size() == 0) begin
                check_val("beat_unexpected", 32'(bus.BeatDone), 32'h0);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check_val("beat_lane", 32'(bus.BeatDone), 32'(8'b1 << b.lane));
                check_val("beat_sel",  32'(sel()),        32'(b.lane));
                check_val("beat_data", 32'(bus.BusData),  32'(b.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ResetN       = 1'b0;
        bus.Req      = 8'hFF;
        bus.BusReady = 1'b1;
        for (int unsigned i = 0; i < 8; i++) bus.DataIn[i*W +: W] = lane_val(i);

        // T1 reset
        tick(2);
        check_val("t1_grant", 32'(bus.Grant),    32'h0);
        check_val("t1_valid", 32'(bus.BusValid), 32'h0);
        check_val("t1_sel",   32'(sel()),        32'h0);
        check_val("t1_done",  32'(bus.BeatDone), 32'h0);
        bus.Req = '0;
        ResetN  = 1'b1;
        tick(1);
        mon_en = 1'b1;

        // T2 single requester, back-to-back regrant
        bus.BusReady = 1'b1;
        bus.Req      = 8'h20;
        expect_beats(5, 8);
        tick(1);
        check_val("t2_grant",  32'(bus.Grant),    32'h20);
        check_val("t2_sel",    32'(sel()),        32'h5);
        check_val("t2_data",   32'(bus.BusData),  32'hA5A5);
        check_val("t2_valid",  32'(bus.BusValid), 32'h1);
        tick(4);
        check_val("t2_bubble_grant", 32'(bus.Grant),    32'h0);
        check_val("t2_bubble_valid", 32'(bus.BusValid), 32'h0);
        tick(1);
        check_val("t2_regrant", 32'(bus.Grant), 32'h20);
        tick(4);
        check_val("t2_release", 32'(bus.Grant), 32'h0);
        bus.Req = '0;
        tick(1);
        check_val("t2_drain", 32'(sb.size()), 32'h0);

        // T3 round robin with wrap-around
        do_reset();
        bus.Req = 8'h81;
        expect_beats(0, 4);
        expect_beats(7, 4);
        expect_beats(0, 4);
        tick(1);
        check_val("t3_g0",  32'(bus.Grant), 32'h01);
        tick(4);
        check_val("t3_b0",  32'(bus.Grant), 32'h00);
        tick(1);
        check_val("t3_g7",  32'(bus.Grant), 32'h80);
        tick(4);
        check_val("t3_b7",  32'(bus.Grant), 32'h00);
        tick(1);
        check_val("t3_g0b", 32'(bus.Grant), 32'h01);
        tick(4);
        check_val("t3_end", 32'(bus.Grant), 32'h00);
        bus.Req = '0;
        tick(1);
        check_val("t3_drain", 32'(sb.size()), 32'h0);

        // T4 backpressure on lane 2
        bus.Req      = 8'h04;
        bus.BusReady = 1'b0;
        tick(1);
        check_val("t4_grant", 32'(bus.Grant), 32'h04);
        for (int unsigned c = 0; c < 3; c++) begin
            if (c != 0) tick(1);
            check_val("t4_stall_valid", 32'(bus.BusValid), 32'h1);
            check_val("t4_stall_data",  32'(bus.BusData),  32'(lane_val(2)));
            check_val("t4_stall_done",  32'(bus.BeatDone), 32'h0);
        end
        bus.BusReady = 1'b1;
        expect_beats(2, 4);
        #1;
        check_val("t4_first_done", 32'(bus.BeatDone), 32'h04);
        tick(3);
        check_val("t4_still_granted", 32'(bus.Grant), 32'h04);
        tick(1);
        check_val("t4_release", 32'(bus.Grant), 32'h00);
        bus.Req = '0;
        tick(1);
        check_val("t4_drain", 32'(sb.size()), 32'h0);

        // T5 abort after two beats
        do_reset();
        bus.Req = 8'h09;
        expect_beats(0, 2);
        tick(1);
        check_val("t5_grant0", 32'(bus.Grant), 32'h01);
        tick(2);
        bus.Req = 8'h08;
        #1;
        check_val("t5_abort_valid", 32'(bus.BusValid), 32'h0);
        check_val("t5_abort_done",  32'(bus.BeatDone), 32'h0);
        expect_beats(3, 4);
        tick(1);
        check_val("t5_idle", 32'(bus.Grant), 32'h00);
        tick(1);
        check_val("t5_grant3", 32'(bus.Grant), 32'h08);
        tick(4);
        check_val("t5_release", 32'(bus.Grant), 32'h00);
        bus.Req = '0;
        tick(1);
        check_val("t5_drain", 32'(sb.size()), 32'h0);

        // T6 reset in the middle of a burst
        do_reset();
        bus.Req      = 8'h10;
        bus.BusReady = 1'b1;
        expect_beats(4, 1);
        tick(1);
        check_val("t6_grant", 32'(bus.Grant), 32'h10);
        check_val("t6_sel",   32'(sel()),     32'h4);
        tick(1);
        ResetN       = 1'b0;
        bus.BusReady = 1'b0;
        tick(1);
        check_val("t6_rst_grant", 32'(bus.Grant),    32'h0);
        check_val("t6_rst_valid", 32'(bus.BusValid), 32'h0);
        check_val("t6_rst_sel",   32'(sel()),        32'h0);
        check_val("t6_rst_done",  32'(bus.BeatDone), 32'h0);
        ResetN       = 1'b1;
        bus.BusReady = 1'b1;
        expect_beats(4, 4);
        tick(1);
        check_val("t6_regrant", 32'(bus.Grant), 32'h10);
        check_val("t6_resel",   32'(sel()),     32'h4);
        tick(4);
        check_val("t6_release", 32'(bus.Grant), 32'h00);
        bus.Req = '0;
        tick(1);
        check_val("t6_drain", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
